// File: rtl/regfile_port_ctrl_if.sv
// Pipeline-side request/response bundle for regfile_port_ctrl.
// master = decode/writeback side, slave = the controller.
interface regfile_port_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_src1;
  logic [ADDR_W-1:0] rd_src2;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_src1, rd_src2,
    input  rd_ready, rd_valid, rd_data1, rd_data2
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_src1, rd_src2,
    output rd_ready, rd_valid, rd_data1, rd_data2
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Array-side access controller for the register-file bit-cell grid: write stage,
// 3-state read FSM with write bypass. Optional macro REGFILE_ZERO_REG_EN hardwires r0 to zero.
module regfile_port_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_port_ctrl_if.slave  bus,
  output logic [NUM_REGS-1:0] write_en,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] read_en1,
  output logic [NUM_REGS-1:0] read_en2,
  input  logic [DATA_W-1:0]   bitline1,
  input  logic [DATA_W-1:0]   bitline2
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                accept_s;
  logic [NUM_REGS-1:0] write_en_r;
  logic [DATA_W-1:0]   write_data_r;
  logic [NUM_REGS-1:0] read_en1_r;
  logic [NUM_REGS-1:0] read_en2_r;
  logic                rd_ready_r;
  logic                rd_valid_r;
  logic [DATA_W-1:0]   rd_data1_r;
  logic [DATA_W-1:0]   rd_data2_r;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    logic ok;
    ok = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
`ifdef REGFILE_ZERO_REG_EN
    ok = ok && (addr != {ADDR_W{1'b0}});
`endif
    return ok;
  endfunction

  // One-hot row select; all-zero for rows that must never be touched.
  function automatic logic [NUM_REGS-1:0] row_sel(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] sel;
    sel = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = addr_ok(addr) && (addr == ADDR_W'(i));
    end
    return sel;
  endfunction

  // A write landing in the DRIVE cycle on the enabled row wins over the bitline.
  function automatic logic [DATA_W-1:0] port_capture(
    input logic [NUM_REGS-1:0] ren,
    input logic [NUM_REGS-1:0] wen,
    input logic [DATA_W-1:0]   wdata,
    input logic [DATA_W-1:0]   bl
  );
    logic [DATA_W-1:0] v;
    if (|(ren & wen)) begin
      v = wdata;
    end else if (|ren) begin
      v = bl;
    end else begin
      v = {DATA_W{1'b0}};
    end
    return v;
  endfunction

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rd_req) begin
          accept_s = 1'b1;
          state_s  = DRIVE;
        end else begin
          state_s  = IDLE;
        end
      end
      DRIVE:   state_s = CAPTURE;
      CAPTURE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Write stage: one registered write per cycle, dropped rows drive nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_r   <= {NUM_REGS{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end else if (bus.wr_req && addr_ok(bus.wr_addr)) begin
      write_en_r   <= row_sel(bus.wr_addr);
      write_data_r <= bus.wr_data;
    end else begin
      write_en_r   <= {NUM_REGS{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end
  end

  // Read path: enables live only in DRIVE, data captured at the end of DRIVE
  always_ff @(posedge clk) begin
    if (rst) begin
      read_en1_r <= {NUM_REGS{1'b0}};
      read_en2_r <= {NUM_REGS{1'b0}};
      rd_ready_r <= 1'b1;
      rd_valid_r <= 1'b0;
      rd_data1_r <= {DATA_W{1'b0}};
      rd_data2_r <= {DATA_W{1'b0}};
    end else begin
      rd_ready_r <= (state_s == IDLE);
      rd_valid_r <= (state_r == DRIVE);
      if (accept_s) begin
        read_en1_r <= row_sel(bus.rd_src1);
        read_en2_r <= row_sel(bus.rd_src2);
      end else begin
        read_en1_r <= {NUM_REGS{1'b0}};
        read_en2_r <= {NUM_REGS{1'b0}};
      end
      if (state_r == DRIVE) begin
        rd_data1_r <= port_capture(read_en1_r, write_en_r, write_data_r, bitline1);
        rd_data2_r <= port_capture(read_en2_r, write_en_r, write_data_r, bitline2);
      end else begin
        rd_data1_r <= rd_data1_r;
        rd_data2_r <= rd_data2_r;
      end
    end
  end

  assign write_en     = write_en_r;
  assign write_data   = write_data_r;
  assign read_en1     = read_en1_r;
  assign read_en2     = read_en2_r;
  assign bus.rd_ready = rd_ready_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data1 = rd_data1_r;
  assign bus.rd_data2 = rd_data2_r;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural bit-cell array on the bitlines.
module tb_regfile_port_ctrl;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] write_en;
  logic [15:0] write_data;
  logic [15:0] read_en1;
  logic [15:0] read_en2;
  logic [15:0] bitline1;
  logic [15:0] bitline2;
  logic [15:0] mem [16];
  int          checks;
  int          failures;
  int          valids;

  regfile_port_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_port_ctrl #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en1   (read_en1),
    .read_en2   (read_en2),
    .bitline1   (bitline1),
    .bitline2   (bitline2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-cell array: rows update at the end of a cycle with write_en asserted
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (write_en[i]) mem[i] <= write_data;
    end
  end

  // Resolved bitlines: OR of every enabled row, 0 when floating
  always_comb begin
    bitline1 = 16'h0000;
    bitline2 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (read_en1[i]) bitline1 = bitline1 | mem[i];
      if (read_en2[i]) bitline2 = bitline2 | mem[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    valids   = 0;
    foreach (mem[i]) mem[i] = 16'h0000;
    rst = 1'b1;
    bus.wr_req = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'h0000;
    bus.rd_req = 1'b0; bus.rd_src1 = 4'd0; bus.rd_src2 = 4'd0;
    #1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_write_en", 32'(write_en), 32'h0);
    chk("rst_write_data", 32'(write_data), 32'h0);
    chk("rst_read_en1", 32'(read_en1), 32'h0);
    chk("rst_read_en2", 32'(read_en2), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_rd_data1", 32'(bus.rd_data1), 32'h0);
    chk("rst_rd_data2", 32'(bus.rd_data2), 32'h0);
    chk("rst_rd_ready", 32'(bus.rd_ready), 32'h1);

    // Preload r3, then write r5 and read it back
    bus.wr_req = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h1234;
    tick();
    chk("pre_write_en", 32'(write_en), 32'h0008);
    bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
    tick();
    chk("wr_write_en", 32'(write_en), 32'h0020);
    chk("wr_write_data", 32'(write_data), 32'hBEEF);
    bus.wr_req = 1'b0;
    tick();
    chk("wr_write_en_off", 32'(write_en), 32'h0);
    bus.rd_req = 1'b1; bus.rd_src1 = 4'd5; bus.rd_src2 = 4'd3;
    tick();
    bus.rd_req = 1'b0;
    chk("rd_read_en1", 32'(read_en1), 32'h0020);
    chk("rd_read_en2", 32'(read_en2), 32'h0008);
    chk("rd_ready_drive", 32'(bus.rd_ready), 32'h0);
    chk("rd_valid_drive", 32'(bus.rd_valid), 32'h0);
    tick();
    chk("rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("rd_data1", 32'(bus.rd_data1), 32'hBEEF);
    chk("rd_data2", 32'(bus.rd_data2), 32'h1234);
    chk("rd_en_off_capture", 32'(read_en1 | read_en2), 32'h0);
    chk("rd_ready_capture", 32'(bus.rd_ready), 32'h0);
    tick();
    chk("rd_valid_drop", 32'(bus.rd_valid), 32'h0);
    chk("rd_ready_back", 32'(bus.rd_ready), 32'h1);
    chk("rd_data1_hold", 32'(bus.rd_data1), 32'hBEEF);

    // Same-cycle bypass on r7, later write invisible
    bus.wr_req = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0001;
    tick();
    bus.wr_req = 1'b0;
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'hA5A5;
    bus.rd_req = 1'b1; bus.rd_src1 = 4'd7; bus.rd_src2 = 4'd7;
    tick();
    bus.rd_req = 1'b0;
    bus.wr_data = 16'h5A5A;
    chk("byp_read_en1", 32'(read_en1), 32'h0080);
    chk("byp_read_en2", 32'(read_en2), 32'h0080);
    chk("byp_write_en", 32'(write_en), 32'h0080);
    tick();
    bus.wr_req = 1'b0;
    chk("byp_rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("byp_rd_data1", 32'(bus.rd_data1), 32'hA5A5);
    chk("byp_rd_data2", 32'(bus.rd_data2), 32'hA5A5);
    tick();

    // Busy handling: rd_req held for 6 cycles
    bus.rd_src1 = 4'd5; bus.rd_src2 = 4'd7;
    for (int k = 0; k < 8; k++) begin
      bus.rd_req = (k < 6);
      chk($sformatf("busy_ready_%0d", k), 32'(bus.rd_ready), ((k % 3) == 0 || k >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("busy_valid_%0d", k), 32'(bus.rd_valid), (k == 2 || k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("busy_en1_%0d", k), 32'(read_en1), (k == 1 || k == 4) ? 32'h0020 : 32'h0);
      if (bus.rd_valid) valids++;
      if (k == 5) begin
        chk("busy_data1", 32'(bus.rd_data1), 32'hBEEF);
        chk("busy_data2", 32'(bus.rd_data2), 32'h5A5A);
      end
      tick();
    end
    chk("busy_valid_count", 32'(valids), 32'd2);

    // Reset during DRIVE aborts the read and the pending write
    bus.rd_req = 1'b1; bus.rd_src1 = 4'd3; bus.rd_src2 = 4'd5;
    tick();
    bus.rd_req = 1'b0;
    chk("abort_drive_en1", 32'(read_en1), 32'h0008);
    rst = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h7777;
    tick();
    rst = 1'b0;
    bus.wr_req = 1'b0;
    chk("abort_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("abort_read_en", 32'(read_en1 | read_en2), 32'h0);
    chk("abort_write_en", 32'(write_en), 32'h0);
    chk("abort_rd_ready", 32'(bus.rd_ready), 32'h1);
    chk("abort_rd_data1", 32'(bus.rd_data1), 32'h0);
    tick();
    chk("abort_rd_valid_later", 32'(bus.rd_valid), 32'h0);

    // Register 0
    bus.wr_req = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'hFFFF;
    tick();
    bus.wr_req = 1'b0;
    chk("r0_write_en", 32'(write_en), ZERO_REG ? 32'h0 : 32'h0001);
    tick();
    bus.rd_req = 1'b1; bus.rd_src1 = 4'd0; bus.rd_src2 = 4'd5;
    tick();
    bus.rd_req = 1'b0;
    chk("r0_read_en1", 32'(read_en1), ZERO_REG ? 32'h0 : 32'h0001);
    chk("r0_read_en2", 32'(read_en2), 32'h0020);
    tick();
    chk("r0_rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("r0_rd_data1", 32'(bus.rd_data1), ZERO_REG ? 32'h0 : 32'hFFFF);
    chk("r0_rd_data2", 32'(bus.rd_data2), 32'hBEEF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Access controller on the array side of the register-file bit-cell grid.
- Drives the cells' write data, one-hot write enables and one-hot per-port read enables.
- Samples the two resolved tri-state bitline buses and returns registered read data with a valid strobe.
- Sits between decode/writeback and the storage array. Provides same-cycle write-to-read bypass so the pipeline never observes a stale value.

Parameters:
- NUM_REGS, 16, number of registers (rows) in the array.
- DATA_W, 16, register width in bits (bitline bus width).
- ADDR_W, 4, register address width; NUM_REGS <= 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_req  input  1  write request; always accepted.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  DATA_W  write value.
- rd_req  input  1  read request; accepted only when rd_ready=1.
- rd_src1  input  ADDR_W  port-1 source register.
- rd_src2  input  ADDR_W  port-2 source register.
- rd_ready  output  1  controller can accept a read.
- write_en  output  NUM_REGS  one-hot row write enable to the cells.
- write_data  output  DATA_W  data bus to all cell D inputs.
- read_en1  output  NUM_REGS  one-hot row enable onto bitline bus 1.
- read_en2  output  NUM_REGS  one-hot row enable onto bitline bus 2.
- bitline1  input  DATA_W  resolved bitline bus 1.
- bitline2  input  DATA_W  resolved bitline bus 2.
- rd_valid  output  1  one-cycle strobe; rd_data1/rd_data2 valid.
- rd_data1  output  DATA_W  port-1 read result (held until next rd_valid).
- rd_data2  output  DATA_W  port-2 read result.

Behaviour:
- Reset values:
  - State IDLE; write stage empty.
  - write_en, read_en1, read_en2, write_data, rd_valid, rd_data1, rd_data2 all 0.
  - rd_ready=1 in the cycle after rst deasserts.
- Write path:
  - Accepted write at cycle t is registered. write_en is one-hot at wr_addr and write_data=wr_data during t+1 only.
  - The cell updates at the end of t+1.
  - One write per cycle; back-to-back writes pipeline with no bubble.
- Read FSM, three states:
  - IDLE: rd_ready=1. rd_req latches rd_src1/rd_src2 -> DRIVE.
  - DRIVE: rd_ready=0. read_en1/read_en2 are one-hot at the latched addresses for exactly this cycle. Bitlines are captured at the clock edge ending DRIVE -> CAPTURE.
  - CAPTURE: rd_valid=1 with captured data, rd_ready=0 -> IDLE.
  - Read latency is 2 cycles from acceptance to rd_valid. Maximum throughput is one read per 3 cycles.
- rd_req while rd_ready=0 is ignored; no queuing.
- Both ports may address the same register; both enables are asserted and both get the same value.
- Bypass:
  - If write_en is active in the DRIVE cycle for an address equal to a latched source, that port captures write_data instead of its bitline.
  - Net rule: a read reflects every write accepted in or before its rd_req acceptance cycle.
  - Writes accepted during DRIVE or CAPTURE are not visible to that read.
- Out-of-range address (>= NUM_REGS):
  - Write is dropped; write_en stays all-zero.
  - Read asserts no enable for that port and returns 0.
- rst asserted mid-read aborts the read. No rd_valid is produced, the pending write is discarded, and all enables are 0 the next cycle.
- read_en1/read_en2 are never asserted outside DRIVE, so the bitlines float when idle.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined, register 0 is hardwired to zero:
  - Writes to address 0 are dropped (no write_en bit 0).
  - Reads of address 0 assert no enable and return 0; bypass never applies to address 0.
- When undefined, register 0 is an ordinary register.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> all outputs 0, rd_ready=1, read_en1/read_en2=0 every idle cycle.
- Write then read (array model on bitlines):
  - Stimulus: write r5=0xBEEF at t, rd_req src1=5 src2=3 at t+2 (r3 preloaded 0x1234).
  - Response: write_en=16'h0020 at t+1; read_en1=16'h0020, read_en2=16'h0008 at t+3; rd_valid at t+4 with 0xBEEF/0x1234.
- Same-cycle bypass:
  - Stimulus: r7 holds 0x0001; wr_req r7=0xA5A5 and rd_req src1=7 src2=7 in the same cycle.
  - Response: rd_data1=rd_data2=0xA5A5. A write to r7 issued one cycle later is not reflected (0xA5A5 still returned).
- Busy handling: rd_req held high 6 cycles -> exactly 2 reads accepted, rd_valid pulses 2 and 5 cycles after the first acceptance, rd_ready low during DRIVE/CAPTURE.
- Reset mid-read: rd_req at t, rst at t+1 -> no rd_valid at t+2, enables 0 at t+2, rd_ready=1 at t+2.
- Register 0 (REGFILE_ZERO_REG_EN defined): write r0=0xFFFF then read src1=0 -> write_en stays 0, read_en1 stays 0, rd_data1=0x0000. Undefined: rd_data1=0xFFFF.
